// File: rtl/pipeline_debug_controller_if.sv
// Command link and register-file write-back bundle for pipeline_debug_controller.
//   cmd / cmd_valid / cmd_ready : host command byte handshake (byte taken on valid & ready)
//   wb_in_*                     : write-back request coming from the pipeline
//   wb_out_*                    : write-back port driven into the decoder register file
// master = host + pipeline side, slave = the controller.
interface pipeline_debug_controller_if #(
   parameter int unsigned NB_DATA           = 32,
   parameter int unsigned NB_ADDR_REGISTERS = 5,
   parameter int unsigned NB_CMD            = 8
);
   logic [NB_CMD-1:0]            cmd;
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [NB_DATA-1:0]           wb_in_data;
   logic [NB_ADDR_REGISTERS-1:0] wb_in_addr;
   logic                         wb_in_en;
   logic [NB_DATA-1:0]           wb_out_data;
   logic [NB_ADDR_REGISTERS-1:0] wb_out_addr;
   logic                         wb_out_en;

   modport master (
      output cmd, cmd_valid, wb_in_data, wb_in_addr, wb_in_en,
      input  cmd_ready, wb_out_data, wb_out_addr, wb_out_en
   );

   modport slave (
      input  cmd, cmd_valid, wb_in_data, wb_in_addr, wb_in_en,
      output cmd_ready, wb_out_data, wb_out_addr, wb_out_en
   );
endinterface

// File: rtl/pipeline_debug_controller.sv
// Debug sequencer: owns the global pipeline stall and shares the register-file write-back
// port between the pipeline and the debug host. Host bytes select LOAD (preload a register
// while frozen), RUN, STEP or pipeline reset.
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   bus (slave)        command byte handshake, pipeline write-back in, register-file port out
//   i_halt             decoder saw HALT (level)
//   o_stall            low only while RUN or STEP
//   o_pipe_reset       synchronous reset pulse to the pipeline stages
//   o_cycle_count      unstalled cycles since the last pipeline reset (saturating)
//   o_done/o_err/o_timeout  one-cycle status pulses
//   o_state            current state encoding
module pipeline_debug_controller #(
   parameter int unsigned NB_DATA           = 32,
   parameter int unsigned N_REGISTERS       = 32,
   parameter int unsigned NB_ADDR_REGISTERS = $clog2(N_REGISTERS),
   parameter int unsigned NB_CMD            = 8,
   parameter int unsigned NB_CYCLE_CNT      = 32,
   parameter int unsigned MAX_RUN_CYCLES    = 1024,
   parameter int unsigned PRST_CYCLES       = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   pipeline_debug_controller_if.slave bus,
   input  logic                      i_halt,
   output logic                      o_stall,
   output logic                      o_pipe_reset,
   output logic [NB_CYCLE_CNT-1:0]   o_cycle_count,
   output logic                      o_done,
   output logic                      o_err,
   output logic                      o_timeout,
   output logic [2:0]                o_state
);
   localparam int unsigned NB_BYTES = NB_DATA / NB_CMD;
   localparam int unsigned NB_BCNT  = $clog2(NB_BYTES + 1);
   localparam int unsigned NB_WDOG  = $clog2(MAX_RUN_CYCLES + 1);
   localparam int unsigned NB_PRST  = $clog2(PRST_CYCLES + 1);

   localparam logic [NB_CMD-1:0] CmdLoad  = NB_CMD'(8'h01);
   localparam logic [NB_CMD-1:0] CmdRun   = NB_CMD'(8'h02);
   localparam logic [NB_CMD-1:0] CmdStep  = NB_CMD'(8'h03);
   localparam logic [NB_CMD-1:0] CmdPrst  = NB_CMD'(8'h04);
   localparam logic [NB_CMD-1:0] CmdBreak = NB_CMD'(8'h05);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StLoadAddr  = 3'd1,
      StLoadData  = 3'd2,
      StLoadWrite = 3'd3,
      StRun       = 3'd4,
      StStep      = 3'd5,
      StPrst      = 3'd6,
      StHalted    = 3'd7
   } state_e;

   state_e                       state_q, state_d;
   logic [NB_ADDR_REGISTERS-1:0] addr_q, addr_d;
   logic [NB_DATA-1:0]           data_q, data_d;
   logic [NB_BCNT-1:0]           bcnt_q, bcnt_d;
   logic                         from_halt_q, from_halt_d;
   logic [NB_WDOG-1:0]           wdog_q, wdog_d;
   logic [NB_PRST-1:0]           prst_q, prst_d;
   logic [NB_CYCLE_CNT-1:0]      cycle_q, cycle_d;
   logic                         done_q, done_d;
   logic                         err_q, err_d;
   logic                         timeout_q, timeout_d;
   logic                         stall_q, stall_d;
   logic                         ready_q, ready_d;
   logic                         pipe_reset_q, pipe_reset_d;

   logic accept;
   logic addr_ok;
   logic debug_write;

   assign accept  = bus.cmd_valid && ready_q;
   // Address byte must fit the register index and must not target the hard-wired r0.
   assign addr_ok = ((bus.cmd >> NB_ADDR_REGISTERS) == '0) &&
                    (bus.cmd[NB_ADDR_REGISTERS-1:0] != '0);

   // The debug write only wins the port when the pipeline is not writing this cycle.
   assign debug_write     = (state_q == StLoadWrite) && !bus.wb_in_en;
   assign bus.wb_out_en   = debug_write ? 1'b1   : bus.wb_in_en;
   assign bus.wb_out_addr = debug_write ? addr_q : bus.wb_in_addr;
   assign bus.wb_out_data = debug_write ? data_q : bus.wb_in_data;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      bcnt_d      = bcnt_q;
      from_halt_d = from_halt_q;
      wdog_d      = wdog_q;
      prst_d      = prst_q;
      cycle_d     = cycle_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      timeout_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               case (bus.cmd)
                  CmdLoad: begin
                     state_d     = StLoadAddr;
                     from_halt_d = 1'b0;
                  end
                  CmdRun: begin
                     state_d = StRun;
                     wdog_d  = '0;
                  end
                  CmdStep: state_d = StStep;
                  CmdPrst: begin
                     state_d = StPrst;
                     prst_d  = '0;
                     cycle_d = '0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         StHalted: begin
            if (accept) begin
               case (bus.cmd)
                  CmdLoad: begin
                     state_d     = StLoadAddr;
                     from_halt_d = 1'b1;
                  end
                  CmdPrst: begin
                     state_d = StPrst;
                     prst_d  = '0;
                     cycle_d = '0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         StLoadAddr: begin
            if (accept) begin
               if (addr_ok) begin
                  addr_d  = bus.cmd[NB_ADDR_REGISTERS-1:0];
                  data_d  = '0;
                  bcnt_d  = '0;
                  state_d = StLoadData;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StLoadData: begin
            if (accept) begin
               data_d = {data_q[NB_DATA-NB_CMD-1:0], bus.cmd};
               bcnt_d = bcnt_q + NB_BCNT'(1);
               if (bcnt_q == NB_BCNT'(NB_BYTES - 1)) begin
                  state_d = StLoadWrite;
               end
            end
         end
         StLoadWrite: begin
            if (!bus.wb_in_en) begin
               done_d  = 1'b1;
               state_d = from_halt_q ? StHalted : StIdle;
            end
         end
         StRun: begin
            if (cycle_q != '1) cycle_d = cycle_q + NB_CYCLE_CNT'(1);
            wdog_d = wdog_q + NB_WDOG'(1);
            if (i_halt) begin
               done_d  = 1'b1;
               state_d = StHalted;
            end else if (accept && (bus.cmd == CmdBreak)) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (wdog_q == NB_WDOG'(MAX_RUN_CYCLES - 1)) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end
         end
         StStep: begin
            if (cycle_q != '1) cycle_d = cycle_q + NB_CYCLE_CNT'(1);
            done_d  = 1'b1;
            state_d = i_halt ? StHalted : StIdle;
         end
         StPrst: begin
            cycle_d = '0;
            prst_d  = prst_q + NB_PRST'(1);
            if (prst_q == NB_PRST'(PRST_CYCLES - 1)) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Control outputs are registered from the next state so they line up with o_state.
      stall_d      = !((state_d == StRun) || (state_d == StStep));
      ready_d      = (state_d == StIdle) || (state_d == StHalted) || (state_d == StLoadAddr) ||
                     (state_d == StLoadData) || (state_d == StRun);
      pipe_reset_d = (state_d == StPrst);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         data_q       <= '0;
         bcnt_q       <= '0;
         from_halt_q  <= 1'b0;
         wdog_q       <= '0;
         prst_q       <= '0;
         cycle_q      <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
         stall_q      <= 1'b1;
         ready_q      <= 1'b1;
         pipe_reset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         bcnt_q       <= bcnt_d;
         from_halt_q  <= from_halt_d;
         wdog_q       <= wdog_d;
         prst_q       <= prst_d;
         cycle_q      <= cycle_d;
         done_q       <= done_d;
         err_q        <= err_d;
         timeout_q    <= timeout_d;
         stall_q      <= stall_d;
         ready_q      <= ready_d;
         pipe_reset_q <= pipe_reset_d;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign o_stall       = stall_q;
   assign o_pipe_reset  = pipe_reset_q;
   assign o_cycle_count = cycle_q;
   assign o_done        = done_q;
   assign o_err         = err_q;
   assign o_timeout     = timeout_q;
   assign o_state       = state_q;
endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Directed + randomized bench for pipeline_debug_controller. The model tracks only the
// observable contract: expected unstalled-cycle total, whether the core should rest in
// IDLE or HALTED, and the register write each LOAD must produce.
module tb_pipeline_debug_controller;
   localparam int unsigned NB_DATA = 32;
   localparam int unsigned NB_ADDR = 5;
   localparam int unsigned NB_CMD  = 8;
   localparam int unsigned NB_CNT  = 32;
   localparam int unsigned MAX_RUN = 1024;
   localparam int unsigned PRST_N  = 4;

   logic              clk;
   logic              rst;
   logic              halt;
   logic              stall;
   logic              pipe_reset;
   logic [NB_CNT-1:0] cycle_count;
   logic              done;
   logic              err;
   logic              timeout;
   logic [2:0]        state;

   pipeline_debug_controller_if #(
      .NB_DATA(NB_DATA), .NB_ADDR_REGISTERS(NB_ADDR), .NB_CMD(NB_CMD)
   ) bus ();

   pipeline_debug_controller #(
      .NB_DATA(NB_DATA), .N_REGISTERS(32), .NB_ADDR_REGISTERS(NB_ADDR), .NB_CMD(NB_CMD),
      .NB_CYCLE_CNT(NB_CNT), .MAX_RUN_CYCLES(MAX_RUN), .PRST_CYCLES(PRST_N)
   ) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus), .i_halt(halt), .o_stall(stall),
      .o_pipe_reset(pipe_reset), .o_cycle_count(cycle_count), .o_done(done), .o_err(err),
      .o_timeout(timeout), .o_state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned exp_count   = 0;
   bit          exp_halted  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] home();
      return exp_halted ? 3'd7 : 3'd0;
   endfunction

   task automatic rand_wb(input logic en);
      bus.wb_in_data = $urandom;
      bus.wb_in_addr = 5'($urandom);
      bus.wb_in_en   = en;
   endtask

   task automatic check_pass(input string tag);
      check(tag, {bus.wb_out_en, bus.wb_out_addr, bus.wb_out_data},
            {bus.wb_in_en, bus.wb_in_addr, bus.wb_in_data});
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.cmd       = b;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
      check("cmd_ready_wait", bus.cmd_ready, 1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic noise();
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'h05) b = 8'h06;
      bus.cmd       = b;
      bus.cmd_valid = 1'($urandom_range(0, 1));
   endtask

   task automatic do_load(input logic [4:0] addr, input logic [31:0] data, input int collide);
      rand_wb(1'b0);
      send_byte(8'h01);
      check("load_addr_state", state, 1);
      send_byte({3'b000, addr});
      check("load_data_state", state, 2);
      send_byte(data[31:24]);
      send_byte(data[23:16]);
      send_byte(data[15:8]);
      rand_wb(collide != 0);
      send_byte(data[7:0]);
      for (int c = 0; c < collide; c++) begin
         check("collide_state", state, 3);
         check_pass("collide_pass");
         tick();
         rand_wb(c + 1 < collide);
         #1;
      end
      check("write_state", state, 3);
      check("write_ready", bus.cmd_ready, 0);
      check("write_port", {bus.wb_out_en, bus.wb_out_addr, bus.wb_out_data},
            {1'b1, addr, data});
      tick();
      check("write_done", done, 1);
      check("write_home", state, home());
      check("write_once", bus.wb_out_en, 0);
   endtask

   task automatic bad_cmd(input logic [7:0] b);
      send_byte(b);
      check("bad_cmd_err", err, 1);
      check("bad_cmd_state", state, home());
      tick();
      check("bad_cmd_pulse", err, 0);
   endtask

   task automatic bad_addr(input logic [7:0] b);
      rand_wb(1'b0);
      send_byte(8'h01);
      send_byte(b);
      check("bad_addr_err", err, 1);
      check("bad_addr_state", state, 0);
      check("bad_addr_nowrite", bus.wb_out_en, 0);
      exp_halted = 0;
   endtask

   task automatic step(input logic with_halt);
      send_byte(8'h03);
      check("step_state", state, 5);
      check("step_stall", stall, 0);
      halt = with_halt;
      tick();
      halt = 1'b0;
      exp_count++;
      exp_halted = with_halt;
      check("step_end_state", state, home());
      check("step_end_stall", stall, 1);
      check("step_done", done, 1);
      check("step_count", cycle_count, exp_count);
   endtask

   task automatic prst();
      send_byte(8'h04);
      for (int i = 0; i < int'(PRST_N); i++) begin
         check("prst_pulse", pipe_reset, 1);
         check("prst_state", state, 6);
         check("prst_count", cycle_count, 0);
         tick();
      end
      exp_count  = 0;
      exp_halted = 0;
      check("prst_end_pulse", pipe_reset, 0);
      check("prst_end_state", state, 0);
      check("prst_done", done, 1);
   endtask

   task automatic run_halt(input int n, input logic with_break);
      send_byte(8'h02);
      check("run_state", state, 4);
      check("run_stall", stall, 0);
      for (int i = 1; i < n; i++) begin
         noise();
         tick();
         check("run_hold", state, 4);
      end
      bus.cmd       = 8'h05;
      bus.cmd_valid = with_break;
      halt          = 1'b1;
      tick();
      halt          = 1'b0;
      bus.cmd_valid = 1'b0;
      exp_count += n;
      exp_halted = 1;
      check("halt_state", state, 7);
      check("halt_stall", stall, 1);
      check("halt_done", done, 1);
      check("halt_count", cycle_count, exp_count);
   endtask

   task automatic run_break(input int j);
      send_byte(8'h02);
      for (int i = 0; i < j; i++) begin
         noise();
         tick();
      end
      bus.cmd       = 8'h05;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      exp_count += j + 1;
      check("break_state", state, 0);
      check("break_done", done, 1);
      check("break_count", cycle_count, exp_count);
   endtask

   initial begin
      rst           = 1'b1;
      halt          = 1'b0;
      bus.cmd       = 8'h00;
      bus.cmd_valid = 1'b0;
      rand_wb(1'b0);
      tick();
      tick();
      check("rst_state", state, 0);
      check("rst_stall", stall, 1);
      check("rst_pipe_reset", pipe_reset, 0);
      check("rst_count", cycle_count, 0);
      check("rst_pulses", {done, err, timeout}, 0);
      check("rst_ready", bus.cmd_ready, 1);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         rand_wb(1'($urandom_range(0, 1)));
         tick();
         check("idle_state", state, 0);
         check("idle_stall", stall, 1);
         check_pass("idle_pass");
      end

      do_load(5'd5, 32'h0000_0045, 0);
      bad_addr(8'h00);
      bad_addr(8'h20);
      bad_addr(8'($urandom_range(32, 255)));
      bad_cmd(8'h00);
      bad_cmd(8'($urandom_range(6, 255)));

      step(1'b0);
      step(1'b0);
      step(1'b0);
      check("three_steps", cycle_count, 3);

      prst();
      run_halt(10, 1'b1);
      check("halt_ten", cycle_count, 10);
      bad_cmd(8'h02);
      bad_cmd(8'h03);
      do_load(5'($urandom_range(1, 31)), $urandom, 0);
      prst();

      do_load(5'($urandom_range(1, 31)), $urandom, 2);

      for (int it = 0; it < 8; it++) begin
         case ($urandom_range(0, 4))
            0: do_load(5'($urandom_range(1, 31)), $urandom, int'($urandom_range(0, 3)));
            1: step(1'b0);
            2: run_break(int'($urandom_range(0, 20)));
            3: begin
               run_halt(int'($urandom_range(1, 25)), 1'($urandom_range(0, 1)));
               do_load(5'($urandom_range(1, 31)), $urandom, int'($urandom_range(0, 2)));
               prst();
            end
            default: begin
               step(1'b1);
               prst();
            end
         endcase
      end

      send_byte(8'h02);
      for (int i = 1; i < int'(MAX_RUN); i++) tick();
      check("wdog_edge_state", state, 4);
      check("wdog_edge_timeout", timeout, 0);
      tick();
      exp_count += MAX_RUN;
      check("wdog_state", state, 0);
      check("wdog_timeout", timeout, 1);
      check("wdog_count", cycle_count, exp_count);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
